drive_cmd_arbiter: RTL and testbench



---
 rtl/drive_pkg.sv | 49 ++++
 rtl/telem_tx_sched.sv | 66 ++++++
 rtl/drive_cmd_arbiter.sv | 133 +++++++++++++
 tb/tb_drive_cmd_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drive_pkg.sv
// Shared encodings for the drive command arbiter: FSM states, one-hot drive
// commands, status codes and the IR / ASCII key tables.
package drive_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_BRAKE,
        ST_BLOCKED
    } state_e;

    localparam logic [7:0] CMD_IDLE  = 8'h00;
    localparam logic [7:0] CMD_FWD   = 8'h02;
    localparam logic [7:0] CMD_LEFT  = 8'h08;
    localparam logic [7:0] CMD_BRAKE = 8'h10;
    localparam logic [7:0] CMD_RIGHT = 8'h20;
    localparam logic [7:0] CMD_BACK  = 8'h80;

    localparam logic [2:0] STAT_IDLE  = 3'b000;
    localparam logic [2:0] STAT_FWD   = 3'b001;
    localparam logic [2:0] STAT_LEFT  = 3'b010;
    localparam logic [2:0] STAT_BRAKE = 3'b011;
    localparam logic [2:0] STAT_RIGHT = 3'b100;
    localparam logic [2:0] STAT_BACK  = 3'b101;

    localparam logic [11:0] IR_FWD   = 12'hD02;
    localparam logic [11:0] IR_LEFT  = 12'hB04;
    localparam logic [11:0] IR_BRAKE = 12'hA05;
    localparam logic [11:0] IR_RIGHT = 12'h906;
    localparam logic [11:0] IR_BACK  = 12'h708;

    localparam logic [7:0] KEY_FWD   = 8'h77;
    localparam logic [7:0] KEY_LEFT  = 8'h61;
    localparam logic [7:0] KEY_BRAKE = 8'h20;
    localparam logic [7:0] KEY_RIGHT = 8'h64;
    localparam logic [7:0] KEY_BACK  = 8'h73;

    function automatic logic [2:0] cmd_to_stat(input logic [7:0] c);
        case (c)
            CMD_FWD:   return STAT_FWD;
            CMD_LEFT:  return STAT_LEFT;
            CMD_BRAKE: return STAT_BRAKE;
            CMD_RIGHT: return STAT_RIGHT;
            CMD_BACK:  return STAT_BACK;
            default:   return STAT_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/telem_tx_sched.sv
// Telemetry scheduler: fires on a status change or a periodic tick and hands a
// {prox, status, 1} byte to the UART transmitter over valid/ready.
module telem_tx_sched #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TELEM_PERIOD_MS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] prox_i,
    input  logic [2:0] stat_i,
    input  logic       tx_ready_i,
    output logic       tx_valid_o,
    output logic [7:0] tx_byte_o
);

    localparam int PERIOD_CYC = (CLK_HZ / 1000) * TELEM_PERIOD_MS;
    localparam int PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYC - 1);

    logic [PW-1:0] per_q, per_d;
    logic [2:0]    stat_prev_q;
    logic          pend_q, pend_d;
    logic          valid_q, valid_d;
    logic [7:0]    byte_q, byte_d;
    logic          tick, trig;

    always_comb begin
        tick    = (per_q == PER_LAST);
        per_d   = tick ? '0 : per_q + PW'(1);
        trig    = tick | (stat_i != stat_prev_q);
        valid_d = valid_q;
        byte_d  = byte_q;
        pend_d  = pend_q;
        if (!valid_q) begin
            if (trig | pend_q) begin
                valid_d = 1'b1;
                byte_d  = {prox_i, stat_i, 1'b1};
                pend_d  = 1'b0;
            end
        end else begin
            // Triggers while busy collapse into one follow-up transfer.
            if (tx_ready_i) valid_d = 1'b0;
            pend_d = pend_q | trig;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_q       <= '0;
            stat_prev_q <= 3'b000;
            pend_q      <= 1'b0;
            valid_q     <= 1'b0;
            byte_q      <= 8'h00;
        end else begin
            per_q       <= per_d;
            stat_prev_q <= stat_i;
            pend_q      <= pend_d;
            valid_q     <= valid_d;
            byte_q      <= byte_d;
        end
    end

    assign tx_valid_o = valid_q;
    assign tx_byte_o  = byte_q;

endmodule

// File: rtl/drive_cmd_arbiter.sv
// Arbitrates IR and UART drive commands into a one-hot motor command, with a
// deadman timeout, forward-obstacle inhibit and telemetry scheduling.
module drive_cmd_arbiter
    import drive_pkg::*;
#(
    parameter int         CLK_HZ          = 50_000_000,
    parameter int         TIMEOUT_MS      = 500,
    parameter int         TELEM_PERIOD_MS = 100,
    parameter logic [3:0] PROX_STOP       = 4'd12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ir_valid,
    input  logic [31:0] ir_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [7:0]  rx_byte,
    input  logic [3:0]  prox_level,
    output logic [7:0]  cmd,
    output logic [2:0]  motor_stat,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_byte
);

    localparam int TIMEOUT_CYC = (CLK_HZ / 1000) * TIMEOUT_MS;
    localparam int DM_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [DM_W-1:0] DM_LOAD = DM_W'(TIMEOUT_CYC - 1);

    state_e          state_q;
    logic [7:0]      cmd_q;
    logic [2:0]      stat_q;
    logic [DM_W-1:0] dm_q;
    logic            ir_valid_q;
    logic            rx_ready_q;

    logic       ir_ev, rx_ev, acc_vld, fwd_blocked;
    logic [7:0] acc_cmd;
    logic       unused_ir;

    assign unused_ir = ^{ir_data[31:28], ir_data[15:0]};

    // IR takes priority; a coincident UART byte is still consumed but dropped.
    always_comb begin
        ir_ev       = ir_valid & ~ir_valid_q;
        rx_ev       = rx_valid & rx_ready_q;
        fwd_blocked = (prox_level >= PROX_STOP);
        acc_vld     = 1'b0;
        acc_cmd     = CMD_IDLE;
        if (ir_ev) begin
            acc_vld = 1'b1;
            case (ir_data[27:16])
                IR_FWD:   acc_cmd = CMD_FWD;
                IR_LEFT:  acc_cmd = CMD_LEFT;
                IR_BRAKE: acc_cmd = CMD_BRAKE;
                IR_RIGHT: acc_cmd = CMD_RIGHT;
                IR_BACK:  acc_cmd = CMD_BACK;
                default:  acc_vld = 1'b0;
            endcase
        end else if (rx_ev) begin
            acc_vld = 1'b1;
            case (rx_byte)
                KEY_FWD:   acc_cmd = CMD_FWD;
                KEY_LEFT:  acc_cmd = CMD_LEFT;
                KEY_BRAKE: acc_cmd = CMD_BRAKE;
                KEY_RIGHT: acc_cmd = CMD_RIGHT;
                KEY_BACK:  acc_cmd = CMD_BACK;
                default:   acc_vld = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_IDLE;
            stat_q     <= STAT_IDLE;
            dm_q       <= '0;
            ir_valid_q <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            ir_valid_q <= ir_valid;
            rx_ready_q <= 1'b1;
            if (acc_vld) begin
                dm_q <= DM_LOAD;
                if (acc_cmd == CMD_BRAKE) begin
                    state_q <= ST_BRAKE;
                    cmd_q   <= CMD_BRAKE;
                    stat_q  <= STAT_BRAKE;
                end else if (acc_cmd == CMD_FWD && fwd_blocked) begin
                    state_q <= ST_BLOCKED;
                    cmd_q   <= CMD_BRAKE;
                    stat_q  <= STAT_BRAKE;
                end else begin
                    state_q <= ST_DRIVE;
                    cmd_q   <= acc_cmd;
                    stat_q  <= cmd_to_stat(acc_cmd);
                end
            end else if (state_q == ST_DRIVE) begin
                // Counter sits at zero on the cycle the deadman fires.
                if (cmd_q == CMD_FWD && fwd_blocked) begin
                    state_q <= ST_BLOCKED;
                    cmd_q   <= CMD_BRAKE;
                    stat_q  <= STAT_BRAKE;
                end else if (dm_q == '0) begin
                    state_q <= ST_BRAKE;
                    cmd_q   <= CMD_BRAKE;
                    stat_q  <= STAT_BRAKE;
                end else begin
                    dm_q <= dm_q - DM_W'(1);
                end
            end
        end
    end

    telem_tx_sched #(
        .CLK_HZ         (CLK_HZ),
        .TELEM_PERIOD_MS(TELEM_PERIOD_MS)
    ) u_telem (
        .clk       (clk),
        .rst       (rst),
        .prox_i    (prox_level),
        .stat_i    (stat_q),
        .tx_ready_i(tx_ready),
        .tx_valid_o(tx_valid),
        .tx_byte_o (tx_byte)
    );

    assign cmd        = cmd_q;
    assign motor_stat = stat_q;
    assign rx_ready   = rx_ready_q;

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Scoreboard bench for drive_cmd_arbiter: a timestamp-based reference model
// queues expected outputs each cycle; a monitor pops and compares them.
module tb_drive_cmd_arbiter;

    localparam int         CLK_HZ          = 1000;
    localparam int         TIMEOUT_MS      = 20;
    localparam int         TELEM_PERIOD_MS = 50;
    localparam logic [3:0] PROX_STOP       = 4'd12;
    localparam int         TO_CYC  = (CLK_HZ / 1000) * TIMEOUT_MS;
    localparam int         PER_CYC = (CLK_HZ / 1000) * TELEM_PERIOD_MS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ir_valid = 1'b0;
    logic [31:0] ir_data = 32'h0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  rx_byte = 8'h0;
    logic [3:0]  prox_level = 4'd0;
    logic [7:0]  cmd;
    logic [2:0]  motor_stat;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_byte;

    drive_cmd_arbiter #(
        .CLK_HZ(CLK_HZ), .TIMEOUT_MS(TIMEOUT_MS),
        .TELEM_PERIOD_MS(TELEM_PERIOD_MS), .PROX_STOP(PROX_STOP)
    ) dut (
        .clk(clk), .rst(rst), .ir_valid(ir_valid), .ir_data(ir_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_byte(rx_byte),
        .prox_level(prox_level), .cmd(cmd), .motor_stat(motor_stat),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] cmd;
        logic [2:0] stat;
        logic       txv;
        logic [7:0] txb;
        logic       rxr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, got, want);
        end
    endtask

    // Reference model: directions 0 FWD,1 LEFT,2 BRAKE,3 RIGHT,4 BACK; mode 0 idle,1 drive,2 stopped.
    int         m_mode, m_dir, m_cyc, m_last, m_n;
    bit         m_prev_ir, m_rxr, m_chg, m_pend, m_tv;
    logic [7:0] m_tb;

    function automatic int ir_key(input logic [11:0] k);
        case (k)
            12'hD02: return 0;
            12'hB04: return 1;
            12'hA05: return 2;
            12'h906: return 3;
            12'h708: return 4;
            default: return -1;
        endcase
    endfunction

    function automatic int asc_key(input logic [7:0] k);
        case (k)
            8'h77:   return 0;
            8'h61:   return 1;
            8'h20:   return 2;
            8'h64:   return 3;
            8'h73:   return 4;
            default: return -1;
        endcase
    endfunction

    function automatic logic [2:0] m_stat();
        if (m_mode == 0) return 3'd0;
        if (m_mode == 2) return 3'd3;
        return 3'(m_dir + 1);
    endfunction

    function automatic logic [7:0] m_cmd();
        if (m_mode == 0) return 8'h00;
        if (m_mode == 2) return 8'h10;
        case (m_dir)
            0:       return 8'h02;
            1:       return 8'h08;
            3:       return 8'h20;
            default: return 8'h80;
        endcase
    endfunction

    initial begin
        logic        s_rst, s_irv, s_rxv, s_txr, trig;
        logic [11:0] s_irk;
        logic [7:0]  s_rxb;
        logic [3:0]  s_prox;
        logic [2:0]  st_pre;
        int          key;
        m_cyc = 0;
        m_last = 0;
        forever begin
            @(posedge clk);
            s_rst = rst; s_irv = ir_valid; s_irk = ir_data[27:16];
            s_rxv = rx_valid; s_rxb = rx_byte; s_prox = prox_level; s_txr = tx_ready;
            m_cyc++;
            if (s_rst) begin
                m_mode = 0; m_dir = 0; m_prev_ir = 0; m_rxr = 0; m_chg = 0;
                m_pend = 0; m_tv = 0; m_tb = 8'h00; m_n = 0;
            end else begin
                m_n++;
                st_pre = m_stat();
                trig = m_chg || (m_n % PER_CYC == 0);
                if (!m_tv) begin
                    if (trig || m_pend) begin
                        m_tv = 1; m_tb = {s_prox, st_pre, 1'b1}; m_pend = 0;
                    end
                end else begin
                    if (s_txr) m_tv = 0;
                    m_pend = m_pend || trig;
                end
                key = -1;
                if (s_irv && !m_prev_ir) key = ir_key(s_irk);
                else if (s_rxv && m_rxr) key = asc_key(s_rxb);
                m_prev_ir = s_irv;
                m_rxr = 1;
                if (key >= 0) begin
                    m_last = m_cyc;
                    if (key == 2 || (key == 0 && s_prox >= PROX_STOP)) m_mode = 2;
                    else begin m_mode = 1; m_dir = key; end
                end else if (m_mode == 1) begin
                    if (m_dir == 0 && s_prox >= PROX_STOP) m_mode = 2;
                    else if (m_cyc - m_last == TO_CYC) m_mode = 2;
                end
                m_chg = (m_stat() != st_pre);
            end
            exp_q.push_back('{cmd: m_cmd(), stat: m_stat(), txv: m_tv, txb: m_tb, rxr: m_rxr});
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) continue;
            e = exp_q.pop_front();
            if (rst) begin
                chk("rst_cmd", 32'(cmd), 32'h00);
                chk("rst_txv", 32'(tx_valid), 32'h0);
                chk("rst_rxr", 32'(rx_ready), 32'h0);
            end else begin
                chk("cmd", 32'(cmd), 32'(e.cmd));
                chk("motor_stat", 32'(motor_stat), 32'(e.stat));
                chk("tx_valid", 32'(tx_valid), 32'(e.txv));
                chk("tx_byte", 32'(tx_byte), 32'(e.txb));
                chk("rx_ready", 32'(rx_ready), 32'(e.rxr));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "bench timeout");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        step();
        rx_valid = 1'b0;
    endtask

    logic [11:0] ir_codes [6] = '{12'hD02, 12'hB04, 12'hA05, 12'h906, 12'h708, 12'h123};
    logic [7:0]  asc_codes[6] = '{8'h77, 8'h61, 8'h20, 8'h64, 8'h73, 8'h41};

    initial begin
        int rate;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();

        // IR forward held for ten cycles: one event only
        ir_data = {4'h0, 12'hD02, 16'h0};
        ir_valid = 1'b1;
        step();
        chk("t1_cmd", 32'(cmd), 32'h02);
        chk("t1_stat", 32'(motor_stat), 32'h1);
        repeat (9) step();
        ir_valid = 1'b0;
        repeat (15) step();

        // UART left, then an unknown byte that must not reload the deadman
        send_rx(8'h61);
        chk("t2_cmd", 32'(cmd), 32'h08);
        repeat (4) step();
        send_rx(8'h41);
        chk("t2_unk", 32'(cmd), 32'h08);
        repeat (14) step();
        chk("t2_pre", 32'(cmd), 32'h08);
        step();
        chk("t2_brake", 32'(cmd), 32'h10);
        repeat (3) step();

        // Simultaneous IR right and UART back
        ir_data = {4'hF, 12'h906, 16'hBEEF};
        ir_valid = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = 8'h73;
        step();
        rx_valid = 1'b0;
        chk("t3_cmd", 32'(cmd), 32'h20);
        chk("t3_rxr", 32'(rx_ready), 32'h1);
        ir_valid = 1'b0;
        repeat (3) step();

        // Obstacle sequence
        prox_level = 4'd5;
        send_rx(8'h77);
        chk("t4_fwd", 32'(cmd), 32'h02);
        repeat (3) step();
        prox_level = 4'd13;
        step();
        chk("t4_block", 32'(cmd), 32'h10);
        prox_level = 4'd2;
        repeat (3) step();
        chk("t4_noresume", 32'(cmd), 32'h10);
        send_rx(8'h64);
        chk("t4_right", 32'(cmd), 32'h20);
        prox_level = 4'd14;
        send_rx(8'h77);
        chk("t4_fwdblk", 32'(cmd), 32'h10);
        prox_level = 4'd0;
        repeat (3) step();

        // Deadman refresh at cycle 15
        send_rx(8'h77);
        repeat (14) step();
        send_rx(8'h77);
        repeat (19) step();
        chk("t5_hold", 32'(cmd), 32'h02);
        step();
        chk("t5_brake", 32'(cmd), 32'h10);
        repeat (3) step();

        // Backpressure across two status changes
        tx_ready = 1'b0;
        send_rx(8'h77);
        repeat (9) step();
        send_rx(8'h61);
        repeat (20) step();
        tx_ready = 1'b1;
        repeat (10) step();

        // Reset in the middle of a held transfer
        tx_ready = 1'b0;
        send_rx(8'h64);
        repeat (4) step();
        chk("t6_busy", 32'(tx_valid), 32'h1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_txv", 32'(tx_valid), 32'h0);
        chk("t6_rst_cmd", 32'(cmd), 32'h00);
        chk("t6_rst_rxr", 32'(rx_ready), 32'h0);
        repeat (2) step();
        rst = 1'b0;
        tx_ready = 1'b1;
        repeat (3) step();

        // Randomized traffic: busy phase then sparse phase
        for (int ph = 0; ph < 2; ph++) begin
            rate = (ph == 0) ? 6 : 40;
            repeat (1200) begin
                if ($urandom_range(0, rate - 1) == 0) begin
                    ir_data = $urandom;
                    ir_data[27:16] = ir_codes[$urandom_range(0, 5)];
                    ir_valid = ~ir_valid;
                end
                rx_valid = ($urandom_range(0, rate - 1) == 0);
                rx_byte  = asc_codes[$urandom_range(0, 5)];
                if ($urandom_range(0, 19) == 0) prox_level = 4'($urandom_range(0, 15));
                tx_ready = ($urandom_range(0, 2) != 0);
                step();
            end
        end
        rx_valid = 1'b0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
